// File: rtl/bbox_scanner.sv
// bbox_scanner: latches a triangle, clamps its bounding box to the screen and
// streams every box pixel in raster order under a valid/ready handshake.
module bbox_scanner #(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               triValid,
   output logic               triReady,
   input  logic signed [10:0] V1_x,
   input  logic signed [10:0] V1_y,
   input  logic signed [10:0] V2_x,
   input  logic signed [10:0] V2_y,
   input  logic signed [10:0] V3_x,
   input  logic signed [10:0] V3_y,
   output logic        [10:0] pixel_x,
   output logic        [10:0] pixel_y,
   output logic signed [10:0] V1_x_out,
   output logic signed [10:0] V1_y_out,
   output logic signed [10:0] V2_x_out,
   output logic signed [10:0] V2_y_out,
   output logic signed [10:0] V3_x_out,
   output logic signed [10:0] V3_y_out,
   output logic               outValid,
   input  logic               outReady,
   output logic               lastPixel
);
   typedef enum logic [1:0] {IDLE, SETUP, SCAN} state_t;
   localparam logic signed [11:0] X_LIM = 12'(SCREEN_W - 1);
   localparam logic signed [11:0] Y_LIM = 12'(SCREEN_H - 1);
   state_t state;
   logic signed [11:0] x1, x2, x3, y1, y2, y3;
   logic signed [11:0] mn_x, mx_x, mn_y, mx_y, lo_x, hi_x, lo_y, hi_y;
   logic [10:0] min_x, max_x, max_y;
   logic empty, at_end;
   // One extra bit so negative vertices and clamping compare correctly
   assign x1 = {V1_x_out[10], V1_x_out};
   assign x2 = {V2_x_out[10], V2_x_out};
   assign x3 = {V3_x_out[10], V3_x_out};
   assign y1 = {V1_y_out[10], V1_y_out};
   assign y2 = {V2_y_out[10], V2_y_out};
   assign y3 = {V3_y_out[10], V3_y_out};
   assign mn_x = x1 < x2 ? (x1 < x3 ? x1 : x3) : (x2 < x3 ? x2 : x3);
   assign mx_x = x1 > x2 ? (x1 > x3 ? x1 : x3) : (x2 > x3 ? x2 : x3);
   assign mn_y = y1 < y2 ? (y1 < y3 ? y1 : y3) : (y2 < y3 ? y2 : y3);
   assign mx_y = y1 > y2 ? (y1 > y3 ? y1 : y3) : (y2 > y3 ? y2 : y3);
   assign lo_x = mn_x < 12'sd0 ? 12'sd0 : mn_x;
   assign hi_x = mx_x > X_LIM ? X_LIM : mx_x;
   assign lo_y = mn_y < 12'sd0 ? 12'sd0 : mn_y;
   assign hi_y = mx_y > Y_LIM ? Y_LIM : mx_y;
   assign empty = lo_x > hi_x || lo_y > hi_y;
   assign at_end = pixel_x == max_x && pixel_y == max_y;
   assign lastPixel = outValid && at_end;
   assign triReady = state == IDLE && !reset;
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         outValid <= 1'b0;
         pixel_x  <= '0;
         pixel_y  <= '0;
         min_x    <= '0;
         max_x    <= '0;
         max_y    <= '0;
         V1_x_out <= '0;
         V1_y_out <= '0;
         V2_x_out <= '0;
         V2_y_out <= '0;
         V3_x_out <= '0;
         V3_y_out <= '0;
      end else begin
         case (state)
            IDLE: if (triValid) begin
               V1_x_out <= V1_x;
               V1_y_out <= V1_y;
               V2_x_out <= V2_x;
               V2_y_out <= V2_y;
               V3_x_out <= V3_x;
               V3_y_out <= V3_y;
               state    <= SETUP;
            end
            SETUP: if (empty) begin
               state <= IDLE;
            end else begin
               pixel_x  <= lo_x[10:0];
               pixel_y  <= lo_y[10:0];
               min_x    <= lo_x[10:0];
               max_x    <= hi_x[10:0];
               max_y    <= hi_y[10:0];
               outValid <= 1'b1;
               state    <= SCAN;
            end
            SCAN: if (outReady) begin
               if (at_end) begin
                  outValid <= 1'b0;
                  state    <= IDLE;
               end else if (pixel_x < max_x) begin
                  pixel_x <= pixel_x + 11'd1;
               end else begin
                  pixel_x <= min_x;
                  pixel_y <= pixel_y + 11'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
